lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_timer.sv | 27 ++
 rtl/lcd_ctrl.sv | 136 +++++++++++++
 tb/tb_lcd_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD controller.
package lcd_pkg;

  localparam int unsigned CNT_W = 17;

  // Bit positions inside the memory-mapped LCD register
  localparam int unsigned IO_ON_BIT   = 31;
  localparam int unsigned IO_TGL_BIT  = 30;
  localparam int unsigned IO_RS_BIT   = 9;
  localparam int unsigned IO_DATA_MSB = 7;

  localparam int unsigned DEF_SETUP_CYC = 3;
  localparam int unsigned DEF_EN_CYC    = 12;
  localparam int unsigned DEF_HOLD_CYC  = 3;
  localparam int unsigned DEF_EXEC_CYC  = 2000;
  localparam int unsigned DEF_CLEAR_CYC = 82000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  // Clear display / return home need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done while the count sits at zero.
module lcd_timer
  import lcd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: toggle-triggered setup / EN pulse / hold / execution wait.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned EN_CYC    = DEF_EN_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned EXEC_CYC  = DEF_EXEC_CYC,
  parameter int unsigned CLEAR_CYC = DEF_CLEAR_CYC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] io_lcd_i,
  output logic        lcd_busy_o,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o
);

  localparam int unsigned CNT_LIM = 1 << CNT_W;

  if (SETUP_CYC == 0 || SETUP_CYC >= CNT_LIM ||
      EN_CYC    == 0 || EN_CYC    >= CNT_LIM ||
      HOLD_CYC  == 0 || HOLD_CYC  >= CNT_LIM ||
      EXEC_CYC  == 0 || EXEC_CYC  >= CNT_LIM ||
      CLEAR_CYC == 0 || CLEAR_CYC >= CNT_LIM) begin : g_bad_cyc
    $error("lcd_ctrl: every *_CYC parameter must be in 1 .. 2**17-1");
  end

  // Timer holds N-1 on entry so a state lasts exactly N cycles
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic             tgl_q, tgl_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, on_q, en_q, rw_q;
  logic             req;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic             unused_io;

  assign unused_io = ^{io_lcd_i[29:10], io_lcd_i[8]};
  assign req       = (io_lcd_i[IO_TGL_BIT] != tgl_q);

  lcd_timer u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tgl_d    = tgl_q;
    rs_d     = rs_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_SETUP;
          tgl_d    = io_lcd_i[IO_TGL_BIT];
          rs_d     = io_lcd_i[IO_RS_BIT];
          data_d   = io_lcd_i[IO_DATA_MSB:0];
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = EN_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? CLEAR_LD : EXEC_LD;
        end
      end
      ST_WAIT: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tgl_q   <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgl_q   <= tgl_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      // Strobes come from the next state so they line up with state entry
      busy_q  <= (state_d != ST_IDLE);
      en_q    <= (state_d == ST_PULSE);
      on_q    <= io_lcd_i[IO_ON_BIT];
      rw_q    <= 1'b0;
    end
  end

  assign lcd_busy_o = busy_q;
  assign lcd_on_o   = on_q;
  assign lcd_en_o   = en_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = rw_q;
  assign lcd_data_o = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized + directed bench for lcd_ctrl against a transaction-timeline model.
module tb_lcd_ctrl;

  localparam int SETUP = 3;
  localparam int EN    = 12;
  localparam int HOLD  = 3;
  localparam int EXEC  = 2000;
  localparam int CLEAR = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io = 32'h0;
  logic        busy, on, en, rs, rw;
  logic [7:0]  data;

  lcd_ctrl #(
    .SETUP_CYC (SETUP),
    .EN_CYC    (EN),
    .HOLD_CYC  (HOLD),
    .EXEC_CYC  (EXEC),
    .CLEAR_CYC (CLEAR)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .io_lcd_i   (io),
    .lcd_busy_o (busy),
    .lcd_on_o   (on),
    .lcd_en_o   (en),
    .lcd_rs_o   (rs),
    .lcd_rw_o   (rw),
    .lcd_data_o (data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a transaction is (start edge, length, rs, data); outputs follow from
  // the offset of the current edge within that window.
  longint     n = 0;
  longint     t0, len;
  bit         last_tgl, m_on, m_rs, in_rst;
  logic [7:0] m_data;

  int busy_cnt, en_cnt, en_rise;
  bit en_prev;

  function automatic longint txn_len(input logic r, input logic [7:0] d);
    longint w = (!r && d >= 8'h01 && d <= 8'h03) ? CLEAR : EXEC;
    return SETUP + EN + HOLD + w;
  endfunction

  function automatic logic [12:0] exp_vec();
    longint k = n - t0;
    logic b = (k >= 0 && k < len);
    logic e = (k >= SETUP && k < SETUP + EN);
    if (in_rst) return 13'h0;
    return {b, m_on, e, m_rs, 1'b0, m_data};
  endfunction

  task automatic model_rst();
    in_rst   = 1'b1;
    last_tgl = 1'b0;
    m_on     = 1'b0;
    m_rs     = 1'b0;
    m_data   = 8'h00;
    t0       = -1000000;
    len      = 0;
  endtask

  task automatic clr_cnt();
    busy_cnt = 0;
    en_cnt   = 0;
    en_rise  = -1;
    en_prev  = 1'b0;
  endtask

  // One clock: apply inputs, advance the model over the edge, check at negedge
  task automatic cyc(input logic [31:0] v);
    io = v;
    n++;
    if (!in_rst) begin
      m_on = v[31];
      if (n >= t0 + len + 1 && v[30] != last_tgl) begin
        t0       = n;
        len      = txn_len(v[9], v[7:0]);
        m_rs     = v[9];
        m_data   = v[7:0];
        last_tgl = v[30];
      end
    end
    @(negedge clk);
    chk("bus", 32'({busy, on, en, rs, rw, data}), 32'(exp_vec()));
    if (en && !en_prev) en_rise = busy_cnt;
    en_prev = en;
    if (busy) busy_cnt++;
    if (en)   en_cnt++;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc(io);
  endtask

  initial begin
    logic [31:0] v;
    model_rst();
    clr_cnt();

    // Reset with a pending toggle; first edge after release starts a data write
    io = 32'h4000_0241;
    run(3);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    clr_cnt();
    run(2030);
    chk("busy_len_data", 32'(busy_cnt), 32'(SETUP + EN + HOLD + EXEC));
    chk("en_len",        32'(en_cnt),   32'(EN));
    chk("en_rise",       32'(en_rise),  32'(SETUP));

    // Clear command (long wait) then function-set (short wait)
    io = 32'h0000_0001;
    clr_cnt();
    run(5030);
    chk("busy_len_clear", 32'(busy_cnt), 32'(SETUP + EN + HOLD + CLEAR));
    io = 32'h4000_0038;
    clr_cnt();
    run(2030);
    chk("busy_len_cmd", 32'(busy_cnt), 32'(SETUP + EN + HOLD + EXEC));

    // Data change + toggle flip during PULSE is deferred to a second write
    io = 32'h0000_0241;
    run(6);
    io = 32'h4000_0255;
    run(100);
    chk("pulse_hold_data", 32'(data), 32'h41);
    run(2000);
    chk("second_data", 32'(data), 32'h55);
    chk("second_busy", 32'(busy), 32'h1);
    run(2000);

    // Two flips during WAIT cancel out
    io = 32'h0000_0038;
    clr_cnt();
    run(100);
    io = 32'h4000_0038;
    run(10);
    io = 32'h0000_0038;
    run(2100);
    chk("even_flips_len", 32'(busy_cnt), 32'(SETUP + EN + HOLD + EXEC));

    // Asynchronous reset in the middle of the EN pulse
    io = 32'h4000_0241;
    run(8);
    chk("pre_rst_en", 32'(en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({busy, on, en, rs, rw, data}), 32'h0);
    model_rst();
    io = 32'h0000_0241;
    run(2);
    rst_n  = 1'b1;
    in_rst = 1'b0;
    run(5);
    chk("idle_after_rst", 32'(busy), 32'h0);
    io = 32'h4000_0241;
    run(2030);

    // Power bit follows while idle and while busy
    io = 32'hC000_0241;
    run(1);
    chk("on_idle_set", 32'(on), 32'h1);
    io = 32'h4000_0241;
    run(3);
    io = 32'h8000_0241;
    run(5);
    io = 32'h0000_0241;
    run(1);
    chk("on_busy_clr", 32'(on), 32'h0);
    chk("rw_low", 32'(rw), 32'h0);
    run(2030);

    // Random traffic
    for (int i = 0; i < 30000; i++) begin
      v = io;
      if ($urandom_range(0, 299) == 0) begin
        v[30] = ~v[30];
        if ($urandom_range(0, 2) == 0) begin
          v[9]   = 1'b0;
          v[7:0] = 8'($urandom_range(1, 3));
        end else begin
          v[9]   = 1'($urandom);
          v[7:0] = 8'($urandom);
        end
      end else if ($urandom_range(0, 19) == 0) begin
        v[9:0]   = 10'($urandom);
        v[29:10] = 20'($urandom);
      end
      if ($urandom_range(0, 49) == 0) v[31] = ~v[31];
      cyc(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
